// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the digit-serial add/sub datapath.
//   bcd_digit_t     : one packed BCD digit (0..9 valid, 10..15 invalid)
//   BCD_MAX         : largest legal digit value
//   state_t         : control states of the serial engine
//   nine_comp()     : nine's complement of a digit (9 - d)
//   is_valid_digit(): 1 when the nibble holds a legal BCD digit
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic bcd_digit_t nine_comp(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction

  function automatic logic is_valid_digit(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with decimal correction.
// Ports:
//   a, b  in  4  BCD digits (b may already be nine's-complemented)
//   cin   in  1  carry in
//   s     out 4  corrected BCD sum digit
//   cout  out 1  decimal carry out
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t s,
  output logic       cout
);

  // Worst case 9 + 9 + 1 = 19, so 5 bits hold the binary sum exactly.
  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (sum > 5'd9) begin
      // Adding 6 skips the six unused codes; the 4-bit wrap drops the 16.
      s    = sum[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      s    = sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor, LSD first, one digit per clock.
// Subtraction is a + (10^N - 1 - b) + 1, i.e. ten's complement with the
// initial carry set; the final carry then means "no borrow".
// Ports:
//   clk    in   1         rising-edge clock
//   rst    in   1         asynchronous active-high reset
//   start  in   1         request, sampled only when idle
//   sub    in   1         0: a+b, 1: a-b
//   a, b   in   4*DIGITS  packed BCD operands, digit 0 in [3:0]
//   busy   out  1         digits being processed
//   done   out  1         one-cycle completion pulse
//   o      out  4*DIGITS  result, held until the next accepted start
//   cout   out  1         add overflow (a+b >= 10^DIGITS)
//   neg    out  1         sub result is negative (ten's complement form)
//   err    out  1         an operand nibble was not a BCD digit
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] o,
  output logic                cout,
  output logic                neg,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     b_reg, b_next;
  logic [W-1:0]     o_reg, o_next;
  logic             sub_reg, sub_next;
  logic             carry_reg, carry_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             cout_reg, cout_next;
  logic             neg_reg, neg_next;
  logic             err_reg, err_next;

  // Operand validity is checked on the live inputs so a bad request
  // can be rejected in the same cycle it is accepted.
  logic [DIGITS-1:0] nib_ok;
  logic              ops_ok;

  bcd_digit_t a_dig [DIGITS];
  bcd_digit_t b_dig [DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib_ok[gi] = is_valid_digit(a[gi*4 +: 4]) & is_valid_digit(b[gi*4 +: 4]);
      assign a_dig[gi]  = a_reg[gi*4 +: 4];
      assign b_dig[gi]  = b_reg[gi*4 +: 4];
    end
  endgenerate

  assign ops_ok = &nib_ok;

  // One shared digit adder, fed by the index mux.
  bcd_digit_t cur_a, cur_b, dig_s;
  logic       dig_cout;

  assign cur_a = a_dig[idx_reg];
  assign cur_b = sub_reg ? nine_comp(b_dig[idx_reg]) : b_dig[idx_reg];

  bcd_digit_adder u_digit_adder (
    .a    (cur_a),
    .b    (cur_b),
    .cin  (carry_reg),
    .s    (dig_s),
    .cout (dig_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      o_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
      neg_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      o_reg     <= o_next;
      sub_reg   <= sub_next;
      carry_reg <= carry_next;
      idx_reg   <= idx_next;
      cout_reg  <= cout_next;
      neg_reg   <= neg_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    o_next     = o_reg;
    sub_next   = sub_reg;
    carry_next = carry_reg;
    idx_next   = idx_reg;
    cout_next  = cout_reg;
    neg_next   = neg_reg;
    err_next   = err_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          sub_next   = sub;
          carry_next = sub;
          idx_next   = '0;
          o_next     = '0;
          cout_next  = 1'b0;
          neg_next   = 1'b0;
          err_next   = ~ops_ok;
          state_next = ops_ok ? ST_RUN : ST_DONE;
        end
      end

      ST_RUN: begin
        o_next[{idx_reg, 2'b00} +: 4] = dig_s;
        carry_next = dig_cout;
        if (idx_reg == LAST_IDX) begin
          // Flags are registered here so they are valid together with done.
          idx_next   = '0;
          cout_next  = ~sub_reg & dig_cout;
          neg_next   = sub_reg & ~dig_cout;
          state_next = ST_DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);
  assign o    = o_reg;
  assign cout = cout_reg;
  assign neg  = neg_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
module tb_bcd_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DIGITS=4 instance
  logic        start4, sub4, busy4, done4, cout4, neg4, err4;
  logic [15:0] a4, b4, o4;
  // DIGITS=1 instance
  logic        start1, sub1, busy1, done1, cout1, neg1, err1;
  logic [3:0]  a1, b1, o1;
  // DIGITS=8 instance
  logic        start8, sub8, busy8, done8, cout8, neg8, err8;
  logic [31:0] a8, b8, o8;

  bcd_addsub_serial #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .o(o4), .cout(cout4), .neg(neg4), .err(err4));

  bcd_addsub_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .o(o1), .cout(cout1), .neg(neg1), .err(err1));

  bcd_addsub_serial #(.DIGITS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .o(o8), .cout(cout8), .neg(neg8), .err(err8));

  typedef struct {
    logic [15:0] o;
    logic        cout;
    logic        neg;
    logic        err;
  } res4_t;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    res4_t       exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] o;
    logic        cout;
    logic        neg;
  } res8_t;

  res4_t q4[$];
  res8_t q8[$];
  res4_t m4_e;
  res8_t m8_e;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Decimal reference model for the 8-digit instance.
  function automatic longint bcd2int(input logic [31:0] v);
    longint r = 0;
    for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input longint x);
    logic [31:0] r = '0;
    longint      t = x;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Scoreboard monitors: pop on each done pulse.
  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut4_unexpected_done: got done=1 required no done");
      end else begin
        m4_e = q4.pop_front();
        $display("txn4 o=%h cout=%b neg=%b err=%b (exp o=%h cout=%b neg=%b err=%b)",
                 o4, cout4, neg4, err4, m4_e.o, m4_e.cout, m4_e.neg, m4_e.err);
        check("dut4_o", 64'(o4), 64'(m4_e.o));
        check("dut4_cout", 64'(cout4), 64'(m4_e.cout));
        check("dut4_neg", 64'(neg4), 64'(m4_e.neg));
        check("dut4_err", 64'(err4), 64'(m4_e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut8_unexpected_done: got done=1 required no done");
      end else begin
        m8_e = q8.pop_front();
        $display("txn8 o=%h cout=%b neg=%b (exp o=%h cout=%b neg=%b)",
                 o8, cout8, neg8, m8_e.o, m8_e.cout, m8_e.neg);
        check("dut8_o", 64'(o8), 64'(m8_e.o));
        check("dut8_cout", 64'(cout8), 64'(m8_e.cout));
        check("dut8_neg", 64'(neg8), 64'(m8_e.neg));
        check("dut8_err", 64'(err8), 64'(0));
      end
    end
  end

  // Drive one DIGITS=4 operation; returns in the idle cycle after done.
  task automatic op4(input logic s, input logic [15:0] a, input logic [15:0] b,
                     input res4_t e, input int exp_lat, input string nm);
    int lat;
    q4.push_back(e);
    start4 = 1'b1;
    sub4   = s;
    a4     = a;
    b4     = b;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    if (exp_lat > 1) check({nm, "_busy"}, 64'(busy4), 64'(1));
    lat = 1;
    while (!done4 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_busy_at_done"}, 64'(busy4), 64'(0));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    int    lat;
    int    dcount;
    res4_t e;
    vecs[0] = '{1'b0, 16'h1234, 16'h8766, '{16'h0000, 1'b1, 1'b0, 1'b0}, 5};
    vecs[1] = '{1'b1, 16'h0050, 16'h0123, '{16'h9927, 1'b0, 1'b1, 1'b0}, 5};
    vecs[2] = '{1'b1, 16'h4321, 16'h4321, '{16'h0000, 1'b0, 1'b0, 1'b0}, 5};
    vecs[3] = '{1'b0, 16'h12A4, 16'h0001, '{16'h0000, 1'b0, 1'b0, 1'b1}, 1};
    vecs[4] = '{1'b0, 16'h0001, 16'h0002, '{16'h0003, 1'b0, 1'b0, 1'b0}, 5};
    vecs[5] = '{1'b0, 16'h9999, 16'h0001, '{16'h0000, 1'b1, 1'b0, 1'b0}, 5};
    vecs[6] = '{1'b1, 16'h0000, 16'h0001, '{16'h9999, 1'b0, 1'b1, 1'b0}, 5};
    vecs[7] = '{1'b1, 16'h9999, 16'h0000, '{16'h9999, 1'b0, 1'b0, 1'b0}, 5};
    vecs[8] = '{1'b1, 16'h1111, 16'h00F0, '{16'h0000, 1'b0, 1'b0, 1'b1}, 1};
    vecs[9] = '{1'b0, 16'h4567, 16'h1234, '{16'h5801, 1'b0, 1'b0, 1'b0}, 5};

    rst = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy4), 64'(0));
    check("reset_done", 64'(done4), 64'(0));
    check("reset_o", 64'(o4), 64'(0));
    check("reset_flags", 64'({cout4, neg4, err4}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven vectors, issued back to back.
    for (int i = 0; i < 10; i++) begin
      op4(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Start re-pulsed during RUN with different operands must be ignored.
    q4.push_back('{16'h0999, 1'b0, 1'b0, 1'b0});
    start4 = 1'b1; sub4 = 1'b1; a4 = 16'h1000; b4 = 16'h0001;
    @(posedge clk);
    #1;
    sub4 = 1'b0; a4 = 16'h9999; b4 = 16'h9999;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    lat = 3;
    while (!done4 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignore_start_latency", 64'(lat), 64'(5));
    @(posedge clk);
    #1;
    // Back-to-back: start in the cycle right after done.
    e = '{16'h0579, 1'b0, 1'b0, 1'b0};
    op4(1'b0, 16'h0123, 16'h0456, e, 5, "back_to_back");

    // Reset in the middle of RUN (idx=2): everything clears, no done later.
    start4 = 1'b1; sub4 = 1'b0; a4 = 16'h1111; b4 = 16'h2222;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrun_busy_before_rst", 64'(busy4), 64'(1));
    check("midrun_o_partial", 64'(o4), 64'(16'h0033));
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", 64'(busy4), 64'(0));
    check("midrun_rst_done", 64'(done4), 64'(0));
    check("midrun_rst_o", 64'(o4), 64'(0));
    check("midrun_rst_flags", 64'({cout4, neg4, err4}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done4) dcount++;
    end
    check("midrun_no_done", 64'(dcount), 64'(0));
    @(posedge clk);
    #1;

    // DIGITS=1 corner cases.
    start1 = 1'b1; sub1 = 1'b0; a1 = 4'd9; b1 = 4'd9;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("txn1 add 9+9 o=%h cout=%b lat=%0d", o1, cout1, lat);
    check("d1_add_latency", 64'(lat), 64'(2));
    check("d1_add_o", 64'(o1), 64'(8));
    check("d1_add_cout", 64'(cout1), 64'(1));
    @(posedge clk);
    #1;
    start1 = 1'b1; sub1 = 1'b1; a1 = 4'd3; b1 = 4'd7;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("txn1 sub 3-7 o=%h neg=%b cout=%b lat=%0d", o1, neg1, cout1, lat);
    check("d1_sub_latency", 64'(lat), 64'(2));
    check("d1_sub_o", 64'(o1), 64'(6));
    check("d1_sub_flags", 64'({cout1, neg1}), 64'(2'b01));
    @(posedge clk);
    #1;

    // DIGITS=8 random operations against the decimal model.
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] ra, rb;
      logic        rs;
      longint      va, vb, vr;
      res8_t       r8;
      for (int d = 0; d < 8; d++) begin
        ra[d*4 +: 4] = 4'($urandom_range(0, 9));
        rb[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      rs = 1'($urandom_range(0, 1));
      va = bcd2int(ra);
      vb = bcd2int(rb);
      if (!rs) begin
        vr = va + vb;
        r8 = '{int2bcd(vr % 100000000), (vr >= 100000000), 1'b0};
      end else if (va >= vb) begin
        r8 = '{int2bcd(va - vb), 1'b0, 1'b0};
      end else begin
        r8 = '{int2bcd(100000000 - (vb - va)), 1'b0, 1'b1};
      end
      q8.push_back(r8);
      start8 = 1'b1; sub8 = rs; a8 = ra; b8 = rb;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      lat = 1;
      while (!done8 && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("d8_latency", 64'(lat), 64'(9));
      @(posedge clk);
      #1;
    end

    @(posedge clk);
    #1;
    check("q4_drained", 64'(q4.size()), 64'(0));
    check("q8_drained", 64'(q8.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
